// File: rtl/cordic_request_sched_if.sv
// cordic_request_sched_if: request/grant and CORDIC result signals shared between
// the angle sources, the CORDIC handler and the request scheduler.
interface cordic_request_sched_if #(
  parameter int unsigned ANGLE_W = 9,
  parameter int unsigned RES_W   = 48
);
  logic               kbd_req;
  logic [ANGLE_W-1:0] kbd_angle;
  logic               kbd_gnt;
  logic               rot_req;
  logic [ANGLE_W-1:0] rot_angle;
  logic               rot_gnt;
  logic [ANGLE_W-1:0] angle_out;
  logic [RES_W-1:0]   x_in;
  logic [RES_W-1:0]   y_in;
  logic [RES_W-1:0]   x_res;
  logic [RES_W-1:0]   y_res;
  logic               res_valid;
  logic               res_src;
  logic               busy;
  logic               err;

  // Requesters and CORDIC handler side
  modport master (
    output kbd_req, kbd_angle, rot_req, rot_angle, x_in, y_in,
    input  kbd_gnt, rot_gnt, angle_out, x_res, y_res, res_valid, res_src, busy, err
  );

  // Scheduler side
  modport slave (
    input  kbd_req, kbd_angle, rot_req, rot_angle, x_in, y_in,
    output kbd_gnt, rot_gnt, angle_out, x_res, y_res, res_valid, res_src, busy, err
  );
endinterface

// File: rtl/cordic_request_sched.sv
// cordic_request_sched: shares one CORDIC handler between keyboard and rotary
// encoder angle requests with round-robin arbitration, a fixed settle interval
// and a one-cycle result pulse.
// Optional feature: define CORDIC_RANGE_CHECK_EN to reject accepted angles > 359.
module cordic_request_sched #(
  parameter int unsigned SETTLE_CYCLES = 50,
  parameter int unsigned ANGLE_W       = 9,
  parameter int unsigned RES_W         = 48
) (
  input logic                   clk,
  input logic                   reset,
  cordic_request_sched_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE} state_t;

  localparam logic [9:0] CNT_LAST = 10'(SETTLE_CYCLES - 1);

  state_t             state;
  state_t             state_next;
  logic [9:0]         cnt;
  logic               last_src;
  logic               take_kbd;
  logic               take_rot;
  logic               take;
  logic               bad;
  logic [ANGLE_W-1:0] sel_angle;
  logic [ANGLE_W-1:0] angle_q;
  logic [RES_W-1:0]   x_q;
  logic [RES_W-1:0]   y_q;
  logic               kbd_gnt_q;
  logic               rot_gnt_q;
  logic               res_valid_q;
  logic               res_src_q;

  // On a tie the source that was not served last wins.
  assign take_kbd  = (state == IDLE) && bus.kbd_req && (!bus.rot_req || last_src);
  assign take_rot  = (state == IDLE) && bus.rot_req && !take_kbd;
  assign take      = take_kbd | take_rot;
  assign sel_angle = take_rot ? bus.rot_angle : bus.kbd_angle;

`ifdef CORDIC_RANGE_CHECK_EN
  logic range_err;
  logic err_q;
  assign bad     = 32'(sel_angle) > 32'd359;
  assign bus.err = err_q;
`else
  assign bad     = 1'b0;
  assign bus.err = 1'b0;
`endif

  assign bus.kbd_gnt   = kbd_gnt_q;
  assign bus.rot_gnt   = rot_gnt_q;
  assign bus.angle_out = angle_q;
  assign bus.x_res     = x_q;
  assign bus.y_res     = y_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_src   = res_src_q;
  assign bus.busy      = (state != IDLE);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic; a range-rejected request passes through CAPTURE for one
  // cycle, which then raises err instead of capturing results.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (take) state_next = bad ? CAPTURE : SETTLE;
      SETTLE:  if (cnt == CNT_LAST) state_next = CAPTURE;
      CAPTURE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Grant pulses, angle latch, settle counter and result capture
  always_ff @(posedge clk) begin
    if (reset) begin
      kbd_gnt_q   <= 1'b0;
      rot_gnt_q   <= 1'b0;
      angle_q     <= '0;
      x_q         <= '0;
      y_q         <= '0;
      res_valid_q <= 1'b0;
      res_src_q   <= 1'b0;
      last_src    <= 1'b1;
      cnt         <= '0;
`ifdef CORDIC_RANGE_CHECK_EN
      range_err   <= 1'b0;
      err_q       <= 1'b0;
`endif
    end else begin
      kbd_gnt_q   <= take_kbd;
      rot_gnt_q   <= take_rot;
      res_valid_q <= 1'b0;
`ifdef CORDIC_RANGE_CHECK_EN
      err_q       <= 1'b0;
`endif
      if (take) begin
        last_src  <= take_rot;
        res_src_q <= take_rot;
        cnt       <= '0;
        if (!bad) angle_q <= sel_angle;
`ifdef CORDIC_RANGE_CHECK_EN
        range_err <= bad;
`endif
      end else if (state == SETTLE) begin
        cnt <= cnt + 10'd1;
      end
      if (state == CAPTURE) begin
`ifdef CORDIC_RANGE_CHECK_EN
        if (range_err) begin
          err_q <= 1'b1;
        end else begin
          x_q         <= bus.x_in;
          y_q         <= bus.y_in;
          res_valid_q <= 1'b1;
        end
`else
        x_q         <= bus.x_in;
        y_q         <= bus.y_in;
        res_valid_q <= 1'b1;
`endif
      end
    end
  end
endmodule

// File: tb/tb_cordic_request_sched.sv
// tb_cordic_request_sched: directed table, hand-written corner sequences and
// randomized requesters checked every cycle against a job-timeline model.
module tb_cordic_request_sched;
  localparam int unsigned S       = 50;
  localparam int unsigned ANGLE_W = 9;
  localparam int unsigned RES_W   = 48;
`ifdef CORDIC_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  cordic_request_sched_if #(.ANGLE_W(ANGLE_W), .RES_W(RES_W)) bus ();

  cordic_request_sched #(.SETTLE_CYCLES(S), .ANGLE_W(ANGLE_W), .RES_W(RES_W)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model: jobs as cycle timelines ----------------
  longint             cyc = 0;
  bit                 armed = 0;
  longint             m_kgnt, m_rgnt, m_valid, m_err, m_cap, m_free;
  logic [ANGLE_W-1:0] m_angle, m_ang;
  logic [RES_W-1:0]   m_x, m_y;
  logic               m_src, m_last, pick_rot;

  always @(negedge clk) begin
    if (armed) begin
      chk("m.kbd_gnt",   bus.kbd_gnt,   64'(cyc == m_kgnt));
      chk("m.rot_gnt",   bus.rot_gnt,   64'(cyc == m_rgnt));
      chk("m.res_valid", bus.res_valid, 64'(cyc == m_valid));
      chk("m.err",       bus.err,       64'(cyc == m_err));
      chk("m.busy",      bus.busy,      64'(cyc < m_free));
      chk("m.angle_out", bus.angle_out, 64'(m_angle));
      chk("m.res_src",   bus.res_src,   64'(m_src));
      chk("m.x_res",     bus.x_res,     64'(m_x));
      chk("m.y_res",     bus.y_res,     64'(m_y));
    end
    if (reset) begin
      armed = 1; m_kgnt = -1; m_rgnt = -1; m_valid = -1; m_err = -1; m_cap = -1;
      m_free = 0; m_angle = '0; m_x = '0; m_y = '0; m_src = 0; m_last = 1;
    end else begin
      if (cyc == m_cap) begin m_x = bus.x_in; m_y = bus.y_in; end
      if (cyc >= m_free && (bus.kbd_req || bus.rot_req)) begin
        pick_rot = bus.rot_req && !(bus.kbd_req && m_last);
        m_ang = pick_rot ? bus.rot_angle : bus.kbd_angle;
        if (pick_rot) m_rgnt = cyc + 1; else m_kgnt = cyc + 1;
        m_last = pick_rot;
        m_src  = pick_rot;
        if (RC && m_ang > 359) begin
          m_err = cyc + 2; m_free = cyc + 2;
        end else begin
          m_angle = m_ang; m_cap = cyc + S + 1; m_valid = cyc + S + 2; m_free = cyc + S + 2;
        end
      end
    end
    cyc++;
  end

  // ---------------- directed table ----------------
  typedef struct {
    logic kreq; logic rreq; logic [ANGLE_W-1:0] ka; logic [ANGLE_W-1:0] ra;
    logic ek;   logic er;   logic [ANGLE_W-1:0] eang; logic esrc;
  } vec_t;
  vec_t tv[8];

  task automatic run_job(input vec_t v, input logic [RES_W-1:0] xs, input logic [RES_W-1:0] ys);
    bus.kbd_req = v.kreq; bus.rot_req = v.rreq; bus.kbd_angle = v.ka; bus.rot_angle = v.ra;
    bus.x_in = xs; bus.y_in = ys;
    tick();
    chk("tv.kbd_gnt", bus.kbd_gnt, 64'(v.ek));
    chk("tv.rot_gnt", bus.rot_gnt, 64'(v.er));
    chk("tv.angle_out", bus.angle_out, 64'(v.eang));
    chk("tv.res_src", bus.res_src, 64'(v.esrc));
    chk("tv.busy_rise", bus.busy, 64'(1));
    bus.kbd_req = 0; bus.rot_req = 0;
    repeat (S) tick();
    chk("tv.no_early_valid", bus.res_valid, 64'(0));
    tick();
    chk("tv.res_valid", bus.res_valid, 64'(1));
    chk("tv.x_res", bus.x_res, 64'(xs));
    chk("tv.y_res", bus.y_res, 64'(ys));
    chk("tv.busy_fall", bus.busy, 64'(0));
  endtask

  initial begin
    bit seen;
    reset = 1; bus.kbd_req = 0; bus.rot_req = 0; bus.kbd_angle = '0; bus.rot_angle = '0;
    bus.x_in = '0; bus.y_in = '0;
    // sequence from reset: last_src starts at rotary
    tv[0] = '{1'b1, 1'b0, 9'd90,  9'd0,   1'b1, 1'b0, 9'd90,  1'b0};
    tv[1] = '{1'b1, 1'b1, 9'd10,  9'd20,  1'b0, 1'b1, 9'd20,  1'b1};
    tv[2] = '{1'b1, 1'b1, 9'd30,  9'd40,  1'b1, 1'b0, 9'd30,  1'b0};
    tv[3] = '{1'b0, 1'b1, 9'd0,   9'd123, 1'b0, 1'b1, 9'd123, 1'b1};
    tv[4] = '{1'b0, 1'b1, 9'd0,   9'd200, 1'b0, 1'b1, 9'd200, 1'b1};
    tv[5] = '{1'b1, 1'b1, 9'd45,  9'd46,  1'b1, 1'b0, 9'd45,  1'b0};
    tv[6] = '{1'b1, 1'b1, 9'd359, 9'd0,   1'b0, 1'b1, 9'd0,   1'b1};
    tv[7] = '{1'b1, 1'b0, 9'd359, 9'd0,   1'b1, 1'b0, 9'd359, 1'b0};
    tick(); tick();
    chk("reset.angle_out", bus.angle_out, 64'(0));
    chk("reset.busy", bus.busy, 64'(0));
    chk("reset.x_res", bus.x_res, 64'(0));
    reset = 0;
    tick();
    for (int v = 0; v < 8; v++)
      run_job(tv[v], 48'h1234_5678_9ABC + 48'(v), 48'hFEDC_BA98_7654 - 48'(v));

    // both requests held from reset: keyboard first, rotary granted at T+53
    reset = 1; tick(); reset = 0;
    bus.kbd_req = 1; bus.rot_req = 1; bus.kbd_angle = 9'd11; bus.rot_angle = 9'd22;
    bus.x_in = 48'hAAAA_0000_1111; bus.y_in = 48'h5555_0000_2222;
    tick();
    chk("tie.kbd_gnt", bus.kbd_gnt, 64'(1));
    chk("tie.rot_gnt", bus.rot_gnt, 64'(0));
    bus.kbd_req = 0;
    for (int i = 0; i < S; i++) begin
      tick();
      chk("tie.rot_held_off", bus.rot_gnt, 64'(0));
    end
    tick();
    chk("tie.valid_T52", bus.res_valid, 64'(1));
    chk("tie.src0", bus.res_src, 64'(0));
    chk("tie.busy_fall", bus.busy, 64'(0));
    chk("tie.no_rot_gnt_T52", bus.rot_gnt, 64'(0));
    tick();
    chk("tie.rot_gnt_T53", bus.rot_gnt, 64'(1));
    chk("tie.angle22", bus.angle_out, 64'(22));
    chk("tie.src1", bus.res_src, 64'(1));
    bus.rot_req = 0;
    repeat (S + 1) tick();
    chk("tie.second_valid", bus.res_valid, 64'(1));

    // reset at counter = 20 aborts the job
    bus.kbd_req = 1; bus.kbd_angle = 9'd100; bus.x_in = 48'h0BAD_0BAD_0BAD;
    tick();
    bus.kbd_req = 0;
    repeat (20) tick();
    reset = 1;
    tick();
    reset = 0;
    chk("rst.angle_out", bus.angle_out, 64'(0));
    chk("rst.x_res", bus.x_res, 64'(0));
    chk("rst.y_res", bus.y_res, 64'(0));
    chk("rst.busy", bus.busy, 64'(0));
    chk("rst.res_src", bus.res_src, 64'(0));
    chk("rst.gnts", {bus.kbd_gnt, bus.rot_gnt, bus.res_valid, bus.err}, 64'(0));
    seen = 0;
    repeat (60) begin tick(); seen |= bus.res_valid; end
    chk("rst.no_valid", 64'(seen), 64'(0));
    run_job('{1'b1, 1'b0, 9'd77, 9'd0, 1'b1, 1'b0, 9'd77, 1'b0}, 48'h0000_7777_0001, 48'h0000_7777_0002);

    // out-of-range rotary angle
    bus.rot_req = 1; bus.rot_angle = 9'd400;
    tick();
    chk("rng.rot_gnt", bus.rot_gnt, 64'(1));
    chk("rng.angle_out", bus.angle_out, RC ? 64'(77) : 64'(400));
    chk("rng.res_src", bus.res_src, 64'(1));
    bus.rot_req = 0;
    tick();
    chk("rng.err_T2", bus.err, 64'(RC));
    chk("rng.busy_T2", bus.busy, 64'(!RC));
    seen = 0;
    repeat (55) begin tick(); seen |= bus.res_valid; end
    chk("rng.valid_seen", 64'(seen), 64'(!RC));

    // randomized requesters, checked by the model every cycle
    for (int i = 0; i < 4000; i++) begin
      tick();
      reset = ($urandom_range(0, 599) == 0);
      if (bus.kbd_gnt) bus.kbd_req = 0;
      else if (bus.kbd_req && $urandom_range(0, 99) < 2) bus.kbd_req = 0;
      else if (!bus.kbd_req && $urandom_range(0, 9) == 0) begin
        bus.kbd_req = 1; bus.kbd_angle = ANGLE_W'($urandom_range(0, 511));
      end
      if (bus.rot_gnt) bus.rot_req = 0;
      else if (bus.rot_req && $urandom_range(0, 99) < 2) bus.rot_req = 0;
      else if (!bus.rot_req && $urandom_range(0, 9) == 0) begin
        bus.rot_req = 1; bus.rot_angle = ANGLE_W'($urandom_range(0, 511));
      end
      bus.x_in = RES_W'({$urandom(), $urandom()});
      bus.y_in = RES_W'({$urandom(), $urandom()});
    end
    reset = 0; bus.kbd_req = 0; bus.rot_req = 0;
    repeat (S + 10) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
